// File: rtl/ysyx_23060332_mem_arbiter.sv
// Data-memory port arbiter shared by the IFU (fetch) and the LSU (load/store).
// Round-robin grant on valid/ready request channels, one transaction in flight,
// exactly one memory strobe per transaction and a one-cycle response pulse.
module ysyx_23060332_mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    // IFU request / response
    input  logic              ifu_req_valid_i,
    output logic              ifu_req_ready_o,
    input  logic [ADDR_W-1:0] ifu_addr_i,
    output logic              ifu_rsp_valid_o,
    output logic [DATA_W-1:0] ifu_rdata_o,
    // LSU request / response
    input  logic              lsu_req_valid_i,
    output logic              lsu_req_ready_o,
    input  logic              lsu_wen_i,
    input  logic [ADDR_W-1:0] lsu_addr_i,
    input  logic [DATA_W-1:0] lsu_wdata_i,
    input  logic [7:0]        lsu_wmask_i,
    output logic              lsu_rsp_valid_o,
    output logic [DATA_W-1:0] lsu_rdata_o,
    // Memory port
    output logic              mem_ren_o,
    output logic [ADDR_W-1:0] mem_raddr_o,
    output logic              mem_wen_o,
    output logic [ADDR_W-1:0] mem_waddr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [7:0]        mem_wmask_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int unsigned CntW = $clog2(MEM_LAT + 1);

    if (MEM_LAT < 1) begin : g_bad_lat
        $error("MEM_LAT must be at least 1");
    end

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    typedef enum logic {
        GntIfu = 1'b0,
        GntLsu = 1'b1
    } gnt_e;

    state_e            state_q;
    gnt_e              last_q;
    gnt_e              gnt_q;
    logic              wen_q;
    logic [CntW-1:0]   cnt_q;

    logic              mem_ren_q;
    logic              mem_wen_q;
    logic [ADDR_W-1:0] mem_raddr_q;
    logic [ADDR_W-1:0] mem_waddr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [7:0]        mem_wmask_q;
    logic              ifu_rsp_q;
    logic              lsu_rsp_q;
    logic [DATA_W-1:0] ifu_rdata_q;
    logic [DATA_W-1:0] lsu_rdata_q;

    logic              lsu_gnt;
    logic              ifu_gnt;
    logic              accept;
    logic              req_wen;
    logic [ADDR_W-1:0] req_addr;

    // Round-robin grant: on a tie the master that did not win last time goes first.
    always_comb begin
        lsu_gnt  = lsu_req_valid_i && (!ifu_req_valid_i || (last_q == GntIfu));
        ifu_gnt  = ifu_req_valid_i && !lsu_gnt;
        ifu_req_ready_o = (state_q == StIdle) && ifu_gnt;
        lsu_req_ready_o = (state_q == StIdle) && lsu_gnt;
        accept   = ifu_req_ready_o || lsu_req_ready_o;
        // IFU traffic is always a read
        req_wen  = lsu_gnt && lsu_wen_i;
        req_addr = lsu_gnt ? lsu_addr_i : ifu_addr_i;
    end

    // Transaction FSM with registered strobes, address/data latches and response pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            last_q      <= GntIfu;
            gnt_q       <= GntIfu;
            wen_q       <= 1'b0;
            cnt_q       <= '0;
            mem_ren_q   <= 1'b0;
            mem_wen_q   <= 1'b0;
            mem_raddr_q <= '0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            ifu_rsp_q   <= 1'b0;
            lsu_rsp_q   <= 1'b0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
        end else begin
            // Strobes and response pulses are single-cycle by default
            mem_ren_q <= 1'b0;
            mem_wen_q <= 1'b0;
            ifu_rsp_q <= 1'b0;
            lsu_rsp_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        gnt_q       <= lsu_gnt ? GntLsu : GntIfu;
                        last_q      <= lsu_gnt ? GntLsu : GntIfu;
                        wen_q       <= req_wen;
                        mem_raddr_q <= req_addr;
                        mem_waddr_q <= req_addr;
                        mem_wdata_q <= lsu_gnt ? lsu_wdata_i : '0;
                        mem_wmask_q <= lsu_gnt ? lsu_wmask_i : '0;
                        mem_ren_q   <= !req_wen;
                        mem_wen_q   <= req_wen;
                        cnt_q       <= CntW'(MEM_LAT);
                        state_q     <= StWait;
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        if (gnt_q == GntLsu) begin
                            lsu_rdata_q <= wen_q ? '0 : mem_rdata_i;
                            lsu_rsp_q   <= 1'b1;
                        end else begin
                            ifu_rdata_q <= mem_rdata_i;
                            ifu_rsp_q   <= 1'b1;
                        end
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Output wiring from registered state
    always_comb begin
        mem_ren_o       = mem_ren_q;
        mem_wen_o       = mem_wen_q;
        mem_raddr_o     = mem_raddr_q;
        mem_waddr_o     = mem_waddr_q;
        mem_wdata_o     = mem_wdata_q;
        mem_wmask_o     = mem_wmask_q;
        ifu_rsp_valid_o = ifu_rsp_q;
        lsu_rsp_valid_o = lsu_rsp_q;
        ifu_rdata_o     = ifu_rdata_q;
        lsu_rdata_o     = lsu_rdata_q;
    end

endmodule
